// File: rtl/tns_dec_seq_if.sv
// Handshake bundle for tns_dec_seq: codeword in, decoded value and overflow out.
// master = surrounding lane logic, slave = the decoder.
interface tns_dec_seq_if #(
    parameter int unsigned CW = 28,
    parameter int unsigned DW = 20
) ();
    logic          in_valid;
    logic          in_ready;
    logic [CW-1:0] codein;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] dataout;
    logic          ovf;

    modport master (
        output in_valid, codein, out_ready,
        input  in_ready, out_valid, dataout, ovf
    );

    modport slave (
        input  in_valid, codein, out_ready,
        output in_ready, out_valid, dataout, ovf
    );
endinterface

// File: rtl/tns_dec_seq.sv
// Multi-cycle weighted-numeral decoder: sums per-bit weights of a CW-bit codeword,
// LANES bits per clock, with a sticky overflow flag.
module tns_dec_seq #(
    parameter int unsigned      CW          = 28,
    parameter int unsigned      DW          = 20,
    parameter int unsigned      LANES       = 4,
    parameter int unsigned      WEIGHT_MODE = 0,
    parameter logic [CW*DW-1:0] WEIGHTS     = '0
) (
    input logic         clk,
    input logic         rst_n,
    tns_dec_seq_if.slave bus
);

    localparam int unsigned STEPS = (CW + LANES - 1) / LANES;
    localparam int unsigned PAD   = STEPS * LANES;
    localparam int unsigned CNT_W = $clog2(STEPS) + 1;
    localparam int unsigned SUM_W = DW + $clog2(LANES + 1);

    // Weight table padded to a whole number of lane groups; pad entries are zero.
    function automatic logic [PAD*DW-1:0] gen_weights();
        logic [PAD*DW-1:0] tab;
        logic [DW-1:0]     fa;
        logic [DW-1:0]     fb;
        logic [DW-1:0]     ft;
        tab = '0;
        fa  = DW'(1);
        fb  = DW'(1);
        for (int i = 0; i < int'(CW); i++) begin
            if (WEIGHT_MODE == 0) begin
                tab[i*DW +: DW] = fb;
            end else if (WEIGHT_MODE == 1) begin
                tab[i*DW +: DW] = WEIGHTS[i*DW +: DW];
            end else begin
                tab[i*DW +: DW] = DW'(1) << i;
            end
            ft = fa + fb;
            fa = fb;
            fb = ft;
        end
        return tab;
    endfunction

    localparam logic [PAD*DW-1:0] WTAB = gen_weights();

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e             state_q, state_d;
    logic [PAD-1:0]     cw_q, cw_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]      acc_q, acc_d;
    logic               carry_q, carry_d;

    logic [LANES-1:0]    lane_bits;
    logic [LANES*DW-1:0] lane_wts;
    logic [SUM_W-1:0]    sum;
    int unsigned         base;

    always_comb begin
        base      = 32'(cnt_q) * LANES;
        lane_bits = cw_q[base +: LANES];
        lane_wts  = WTAB[base*DW +: LANES*DW];
        sum       = SUM_W'(acc_q);
        for (int j = 0; j < int'(LANES); j++) begin
            if (lane_bits[j]) begin
                sum = sum + SUM_W'(lane_wts[j*DW +: DW]);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cw_d    = cw_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        carry_d = carry_q;
        unique case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    cw_d    = PAD'(bus.codein);
                    cnt_d   = '0;
                    acc_d   = '0;
                    carry_d = 1'b0;
                    state_d = StRun;
                end
            end
            StRun: begin
                acc_d = sum[DW-1:0];
                if (|sum[SUM_W-1:DW]) begin
                    carry_d = 1'b1;
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(STEPS - 1)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (bus.out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cw_q    <= '0;
            cnt_q   <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cw_q    <= cw_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
        end
    end

    // Handshake outputs come straight from state: no out_ready -> in_ready path.
    assign bus.in_ready  = (state_q == StIdle);
    assign bus.out_valid = (state_q == StDone);
    assign bus.dataout   = acc_q;
    assign bus.ovf       = carry_q;

endmodule

// File: doc/tns_dec_seq.md
# tns_dec_seq

Parametrised, multi-cycle weighted-numeral-system decoder for the CAC codec family. It is the next generation of the fixed 28-wire single-cycle TNS/FNS decoders. A CW-bit codeword is converted to a DW-bit binary value by summing per-bit weights, LANES bits per clock. The block sits on the receive side of a codec lane, with valid/ready handshakes on both sides, and adds an overflow flag and a selectable weight mode.

## Interface
- CW, 28: codeword width in wires.
- DW, 20: output data width; also the width of each weight.
- LANES, 4: codeword bits accumulated per cycle (1..CW).
- WEIGHT_MODE, 0: 0 = Fibonacci (weight of bit i = Fib(i+2), with Fib(1)=Fib(2)=1); 1 = table from WEIGHTS; 2 = binary (weight i = 2^i mod 2^DW).
- WEIGHTS, 0: CW*DW-bit packed table; bits [(i+1)*DW-1 : i*DW] are the weight of codein[i]. Used only when WEIGHT_MODE=1.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  codein valid.
- in_ready  out  1  block can accept a codeword.
- codein  in  CW  codeword.
- out_valid  out  1  dataout/ovf valid.
- out_ready  in  1  downstream accepts the result.
- dataout  out  DW  decoded value, equal to the sum mod 2^DW.
- ovf  out  1  the true sum was ≥ 2^DW for this word.

## Operation
- STEPS = ceil(CW/LANES). Internal state: FSM, codeword register, step counter of width clog2(STEPS)+1, accumulator of DW bits, sticky carry.
- FSM states:
  - IDLE: in_ready=1, out_valid=0.
    - On in_valid, latch codein, clear acc/carry/counter, go to RUN.
  - RUN: in_ready=0, out_valid=0.
    - Each cycle, acc += Σ weight[k]·cw[k] for k = cnt*LANES + j, j = 0..LANES-1.
    - Indices k ≥ CW contribute 0.
    - Any carry out of bit DW-1 sets the sticky carry.
    - cnt++.
    - After step STEPS-1, go to DONE.
  - DONE: out_valid=1. dataout=acc and ovf=carry are held stable.
    - On out_ready, go to IDLE.
- in_ready is registered state only (IDLE). There is no acceptance in DONE and no combinational path from out_ready to in_ready.
- codein is sampled only on the accepting edge. Later changes to codein are ignored.
- Mode 0 and mode 2 weights are elaboration-time constants, generated by a constant function. The WEIGHTS parameter is ignored in these modes.
- The per-cycle adder tree sums up to LANES DW-bit terms plus acc. It is computed at DW+clog2(LANES+1) bits. Any nonzero bits above DW-1 set carry; acc keeps the low DW bits.

## Timing
- Reset values: FSM=IDLE, in_ready=1, out_valid=0, dataout=0, ovf=0, acc=0, cnt=0.
- Accept at edge A (in_valid & in_ready). RUN occupies edges A+1..A+STEPS. out_valid rises after edge A+STEPS.
  - Default: STEPS=7, result visible 7 cycles after the accepting edge.
- Result handshake completes on the edge where out_valid & out_ready. in_ready is 1 from the following cycle.
- Minimum period per word: STEPS+2 cycles (9 with defaults).
- Backpressure: if out_ready=0 in DONE, dataout and ovf hold indefinitely. in_ready stays 0.
- rst_n low in any state, including mid-RUN or DONE: immediate return to reset values. The partial word is discarded and no output is produced.
- in_valid asserted while in_ready=0 is ignored. Upstream must hold it until acceptance.

## Test plan
- Reset: hold rst_n=0, then release -> in_ready=1, out_valid=0, dataout=0, ovf=0. Assert rst_n low for 1 cycle mid-RUN -> out_valid never rises for that word, in_ready=1 next cycle.
- Defaults, codein=28'h0000015 -> dataout=12 (1+3+8), ovf=0. out_valid rises exactly 7 cycles after the accepting edge.
- Defaults, codein=28'h8000000 -> dataout=514229, ovf=0. Then codein=28'h0000000 -> dataout=0, ovf=0.
- Defaults, codein=28'hFFFFFFF -> true sum 1346267 -> dataout=297691, ovf=1. The next word, 28'h0000001, -> dataout=1, ovf=0 (sticky carry cleared per word).
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> dataout and ovf unchanged, in_ready=0, in_valid pulses ignored. Raise out_ready -> in_ready=1 the next cycle, and the following word decodes correctly.
- WEIGHT_MODE=2, CW=8, DW=8, LANES=3 -> STEPS=3. codein=8'hA5 -> dataout=165, ovf=0. WEIGHT_MODE=1 with WEIGHTS all 8'd40 and codein=8'hFF -> 320 -> dataout=64, ovf=1.
